serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial N-bit adder controller that time-shares one 1-bit full-adder cell across all operand bits, LSB first.
- Loads two WIDTH-bit operands on a start request.
- Feeds one bit pair per clock through the cell, registering the carry between cycles.
- Assembles the sum in a shift register and signals completion.
- Sits between a simple requester (testbench or small sequencer) and the 1-bit adder datapath.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- start  input  1  request to begin an addition; honoured only in IDLE.
- x  input  WIDTH  operand A; sampled on the accepting edge only.
- y  input  WIDTH  operand B; sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when result and retenue are valid.
- result  output  WIDTH  sum; held stable from done until the next accepted start.
- retenue  output  1  final carry-out; held with result.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, result=0, retenue=0; shift registers, carry register and bit counter cleared. Reset overrides all other inputs and aborts any operation in progress. No partial result is kept.
- States: IDLE, RUN, DONE. Encoding comes from the package.
- IDLE: on an edge with start=1:
  - load xs<=x, ys<=y, carry<=0 (carry<=sub under the optional feature), cnt<=0;
  - go to RUN; busy=1 from the next cycle.
  - start=0 holds IDLE.
- RUN, each edge:
  - s = xs[0]^ys[0]^carry; c = majority(xs[0], ys[0], carry);
  - xs, ys shift right by one;
  - the result shift register shifts right with s inserted at MSB;
  - carry<=c; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: go to DONE and latch retenue<=c.
  - start is ignored in RUN.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditionally IDLE. start is ignored in DONE.
- Latency: with start accepted at edge E0, RUN occupies edges E1..E_WIDTH, and done is high in the cycle after E_WIDTH. Total is WIDTH+1 cycles from accept to done. Minimum spacing between accepted starts is WIDTH+2 cycles.
- result and retenue change only at RUN edges and at reset. After done they hold until the next accept; they are not cleared at accept.
- Arithmetic is modulo 2^WIDTH; the overflow carry appears only on retenue. The counter is $clog2(WIDTH) bits wide (minimum 1) and never wraps past WIDTH-1.
- WIDTH=1: RUN lasts a single edge; the result is a plain 1-bit full add.
- x and y may change freely after the accepting edge without effect.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - adds input port sub (1 bit), sampled with start;
  - when sub=1, ys loads ~y and the initial carry loads 1, so result = x-y mod 2^WIDTH;
  - retenue=1 means no borrow (x>=y unsigned).
- Undefined: port absent; the block is addition only, and initial carry is always 0.

Decomposition:
- Package serial_add_pkg holds:
  - state typedef (IDLE, RUN, DONE);
  - constant function for counter width from WIDTH;
  - default WIDTH constant.
- One sub-module, add1b_full: the combinational 1-bit full adder (inputs x, y, cin; outputs result, retenue). It is built from two half-adder stages plus an OR, and is instantiated once.
- FSM, counter and shift registers stay in serial_add_ctrl.

Test Plan:
1. Basic add, WIDTH=8: reset, then start with x=0x03, y=0x05 → busy for 8 cycles; done pulses 9 cycles after accept; result=0x08, retenue=0.
2. Wrap-around: x=0xFF, y=0x01 → result=0x00, retenue=1. Then x=0xFF, y=0xFF → result=0xFE, retenue=1.
3. Start ignored when busy: accept x=0x10, y=0x20; pulse start with x=0x01, y=0x01 during RUN and during DONE → result=0x30; only one done pulse.
4. Reset mid-operation: rst_n=0 for one edge at RUN cycle 4 → next cycle state IDLE; busy=0, done=0, result=0, retenue=0; no done pulse. A fresh start with 0x7F+0x01 then gives 0x80, retenue=0.
5. Hold and back-to-back: after done, keep start=0 for 5 cycles → result and retenue stable. Assert start in the first IDLE cycle after DONE → accepted; new result is correct.
6. With SERIAL_ADD_SUB_EN:
   - sub=1, x=0x05, y=0x07 → result=0xFE, retenue=0.
   - x=0x07, y=0x05 → result=0x02, retenue=1.
   - Repeat test 1 at WIDTH=1 with x=1, y=1 → result=0, retenue=1, done 2 cycles after accept.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
package serial_add_pkg;

    // Default operand/sum width in bits.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bit counter width: enough to index WIDTH bits, and never less than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/add1b_full.sv
// Combinational 1-bit full adder: two half-adder stages plus an OR for the carry.
module add1b_full (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic result,
    output logic retenue
);

    logic p;   // first half-adder sum
    logic g1;  // first half-adder carry
    logic g2;  // second half-adder carry

    // First stage adds the operands, second stage folds in the carry.
    assign p       = x ^ y;
    assign g1      = x & y;
    assign result  = p ^ cin;
    assign g2      = p & cin;
    assign retenue = g1 | g2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder controller: one full-adder cell is time-shared
// over all operand bits, LSB first, with the carry registered between cycles.
// Defining SERIAL_ADD_SUB_EN adds a 'sub' input that turns the operation into
// x - y (y inverted, initial carry 1); retenue=1 then means no borrow.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             retenue
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state;
    logic [WIDTH-1:0]  xs;
    logic [WIDTH-1:0]  ys;
    logic              carry;
    logic [CW-1:0]     cnt;

    logic [WIDTH-1:0]  y_load;
    logic              cin_load;
    logic              s;
    logic              c;
    logic [WIDTH-1:0]  result_shift;

    // Operand B and initial carry as loaded on an accepted start.
`ifdef SERIAL_ADD_SUB_EN
    assign y_load   = sub ? ~y : y;
    assign cin_load = sub;
`else
    assign y_load   = y;
    assign cin_load = 1'b0;
`endif

    // The single shared full-adder cell works on the current LSB pair.
    add1b_full u_cell (
        .x       (xs[0]),
        .y       (ys[0]),
        .cin     (carry),
        .result  (s),
        .retenue (c)
    );

    // Result shifts right with the new sum bit entering at the MSB; the
    // concatenation form also covers WIDTH=1 without a zero-width slice.
    assign result_shift = WIDTH'({s, result} >> 1);

    // Controller FSM, bit counter, operand/result shift registers, registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values; blocking would let later lines see new values.
        if (!rst_n) begin
            // NOTE: the shift registers are ordinary flops, not a memory array,
            // so clearing them on reset is cheap and leaves no stale partial sum.
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            xs      <= '0;
            ys      <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            result  <= '0;
            retenue <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xs    <= x;
                        ys    <= y_load;
                        carry <= cin_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    xs     <= xs >> 1;
                    ys     <= ys >> 1;
                    result <= result_shift;
                    carry  <= c;
                    if (cnt == LAST) begin
                        retenue <= c;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: an 8-bit instance exercised with
// directed and random operations, plus a 1-bit instance for the edge case.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         retenue;

    logic         start1;
    logic [0:0]   x1;
    logic [0:0]   y1;
    logic         busy1;
    logic         done1;
    logic [0:0]   result1;
    logic         retenue1;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
    logic         sub1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub     (sub),
`endif
        .x       (x),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .retenue (retenue)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
`ifdef SERIAL_ADD_SUB_EN
        .sub     (sub1),
`endif
        .x       (x1),
        .y       (y1),
        .busy    (busy1),
        .done    (done1),
        .result  (result1),
        .retenue (retenue1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, {carry, sum}.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input bit do_sub);
        longint unsigned bb  = do_sub ? longint'((~b) & {W{1'b1}}) : longint'(b);
        longint unsigned sum = longint'(a) + bb + (do_sub ? 1 : 0);
        return (W + 1)'(sum);
    endfunction

    // Runs one operation on the 8-bit instance and checks timing and result.
    // noisy=1 keeps start asserted with junk operands during RUN and DONE.
    // Returns at the falling edge inside the DONE cycle with start low.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit do_sub, input bit noisy);
        logic [W:0] exp = model(a, b, do_sub);
        int busy_cycles = 0;
        int lat = 0;
        bit seen = 0;
        @(negedge clk);
        start = 1'b1;
        x = a;
        y = b;
`ifdef SERIAL_ADD_SUB_EN
        sub = do_sub;
`endif
        @(posedge clk);
        for (int k = 1; k <= 4 * W + 10; k++) begin
            @(negedge clk);
            start = noisy;
            x = W'($urandom);
            y = W'($urandom);
            if (busy) busy_cycles++;
            if (done) begin
                lat  = k;
                seen = 1;
                break;
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(W + 1));
        check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(W));
        check({tag, " busy_in_done"}, 64'(busy), 64'd0);
        check({tag, " result"}, 64'(result), 64'(exp[W-1:0]));
        check({tag, " retenue"}, 64'(retenue), 64'(exp[W]));
    endtask

    // Runs one 1-bit operation and checks the two-cycle latency and the sum.
    task automatic run_op1(input logic a, input logic b);
        int lat = 0;
        int sum = int'(a) + int'(b);
        @(negedge clk);
        start1 = 1'b1;
        x1 = a;
        y1 = b;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (done1) begin
                lat = k;
                break;
            end
        end
        check("w1 latency", 64'(lat), 64'd2);
        check("w1 result", 64'(result1), 64'(sum & 1));
        check("w1 retenue", 64'(retenue1), 64'(sum >> 1));
    endtask

    initial begin
        logic [W-1:0] held_r;
        logic         held_c;
        bit           extra_done;

        rst_n  = 1'b0;
        start  = 1'b0;
        x      = '0;
        y      = '0;
        start1 = 1'b0;
        x1     = '0;
        y1     = '0;
`ifdef SERIAL_ADD_SUB_EN
        sub  = 1'b0;
        sub1 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset retenue", 64'(retenue), 64'd0);
        rst_n = 1'b1;

        // Basic add and wrap-around cases.
        run_op("basic", 8'h03, 8'h05, 0, 0);
        run_op("wrap1", 8'hFF, 8'h01, 0, 0);
        run_op("wrapff", 8'hFF, 8'hFF, 0, 0);

        // start during RUN and DONE is ignored; no second done pulse.
        run_op("ignore", 8'h10, 8'h20, 0, 1);
        extra_done = 0;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            if (done || busy) extra_done = 1;
        end
        check("ignore no_second_op", 64'(extra_done), 64'd0);
        check("ignore result_kept", 64'(result), 64'h30);

        // Reset in the middle of RUN aborts and clears everything.
        @(negedge clk);
        start = 1'b1;
        x = 8'hAA;
        y = 8'h55;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort result", 64'(result), 64'd0);
        check("abort retenue", 64'(retenue), 64'd0);
        extra_done = 0;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            if (done || busy) extra_done = 1;
        end
        check("abort no_done", 64'(extra_done), 64'd0);
        run_op("after_abort", 8'h7F, 8'h01, 0, 0);

        // Result holds while idle, then a back-to-back start is accepted.
        held_r = result;
        held_c = retenue;
        check("hold ref_result", 64'(held_r), 64'h80);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold result", 64'(result), 64'(held_r));
            check("hold retenue", 64'(retenue), 64'(held_c));
        end
        run_op("b2b_a", 8'h12, 8'h34, 0, 0);
        run_op("b2b_b", 8'hC8, 8'h64, 0, 0);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub_neg", 8'h05, 8'h07, 1, 0);
        run_op("sub_pos", 8'h07, 8'h05, 1, 0);
`endif

        // Random operations against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            bit do_sub = 0;
`ifdef SERIAL_ADD_SUB_EN
            do_sub = bit'($urandom_range(0, 1));
`endif
            run_op("random", W'($urandom), W'($urandom), do_sub, bit'($urandom_range(0, 1)));
        end

        // One-bit instance: full-add truth table for operands.
        run_op1(1'b1, 1'b1);
        run_op1(1'b0, 1'b1);
        run_op1(1'b1, 1'b0);
        run_op1(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
